wallace_mul_arbiter: RTL and testbench
======================================

# wallace_mul_arbiter

Round-robin arbiter and sequencer that shares one pipelined 4x4 Wallace-tree multiplier between `NREQ` independent requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the multiplier one operation per cycle. It tracks each in-flight operation's owner in a tag pipeline matched to the multiplier latency. Products are returned in issue order through a credit-protected response FIFO with backpressure.

## Interface
- `NREQ`, default 4: number of requesters; legal range 2..8.
- `LAT`, default 3: multiplier latency, from the cycle operands are driven on `mul_a`/`mul_b` to the cycle the product is valid on `mul_p`; legal range 1..8.
- `clk`  in  1  clock; all state changes on its rising edge.
- `resetn`  in  1  reset; synchronous, active-low.
- `req_valid`  in  NREQ  per-requester request valid.
- `req_ready`  out  NREQ  per-requester accept; at most one bit set per cycle.
- `req_a`  in  4*NREQ  multiplicand; requester i uses bits [4i+3:4i].
- `req_b`  in  4*NREQ  multiplier; same packing as `req_a`.
- `mul_a`  out  4  operand A to the shared multiplier.
- `mul_b`  out  4  operand B to the shared multiplier.
- `mul_p`  in  8  product from the shared multiplier.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumer accept.
- `rsp_id`  out  clog2(NREQ)  index of the requester that owns `rsp_p`.
- `rsp_p`  out  8  unsigned product.
- `busy`  out  1  high while any operation is in flight or queued.

## Operation
- Constants: `DEPTH` = LAT+1 (response FIFO entries). `credits` counter, range 0..DEPTH.
- Issue enable: `issue_ok` = (credits != 0) | (rsp_valid & rsp_ready). The second term is the same-cycle credit bypass.
- Arbitration:
  - The grant `g` is the first index with `req_valid` set, searching cyclically from `rr_ptr`.
  - An issue occurs when any `req_valid` is set and `issue_ok` is true. The issue raises `req_ready[g]`; all other `req_ready` bits stay 0.
  - `req_ready` is combinational from `req_valid`, `rr_ptr` and `credits`.
- On issue:
  - `mul_a`/`mul_b` are driven combinationally with requester g's operands.
  - `rr_ptr` <= (g+1) mod NREQ.
  - {1, g} enters tag stage 0.
- With no issue: `mul_a`/`mul_b` = 0 and a null tag enters stage 0.
- Tag pipeline: LAT stages of {valid, id}, shifting every cycle with no stall. When stage LAT-1 is valid, {id, mul_p} is written to the FIFO tail in that cycle.
- Response FIFO:
  - Ordered, DEPTH entries, registered outputs.
  - `rsp_valid` = FIFO not empty; `rsp_id`/`rsp_p` = FIFO head.
  - Pop occurs on `rsp_valid & rsp_ready`.
  - Once `rsp_valid` is asserted, `rsp_id`/`rsp_p` hold stable until popped.
- Credit update: `credits` <= credits − issue + pop, so a simultaneous issue and pop leave it unchanged. Overflow is impossible by construction; the bench asserts FIFO count ≤ DEPTH.
- `busy` = (credits != DEPTH).
- Arithmetic: `rsp_p` is the unchanged 8-bit `mul_p`, an unsigned 4x4 product (max 8'hE1). No width extension.

## Timing
- Reset, while `resetn`=0 at an edge:
  - `rr_ptr`=0, all tags invalid, FIFO empty, `credits`=DEPTH.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0, `busy`=0.
  - Forced to 0 during reset: `req_ready`, `mul_a`, `mul_b`.
- Reset mid-operation discards all in-flight and queued operations; no response is produced for them afterwards.
- Latency: request accepted in cycle t gives `rsp_valid` in cycle t+LAT+1 when the FIFO was empty.
- Throughput: one issue per cycle sustained indefinitely while `rsp_ready`=1.
- Stall depth: with `rsp_ready`=0, exactly DEPTH requests are accepted, then all `req_ready` bits stay 0.
- Resume after stall: issuing restarts in the same cycle as the first pop, via the bypass.
- Requester-side handshake:
  - `req_valid` may drop without an accept.
  - The arbiter never accepts from a requester whose `req_valid` is low.
- Fairness: a continuously requesting requester is granted within NREQ issue opportunities.

## Test plan
- Single request (NREQ=4, LAT=3): requester 2, a=4'hF, b=4'hF, accepted in cycle t -> `rsp_valid` in cycle t+4, `rsp_id`=2, `rsp_p`=8'hE1, `busy` high from t+1 to t+4.
- Operand checks: a=4'hA, b=4'h3 -> 8'h1E; a=0, b=4'h9 -> 8'h00; a=4'h7, b=4'h8 -> 8'h38.
- All four requesters valid continuously, `rsp_ready`=1 -> grants 0,1,2,3,0,... one per cycle with no bubbles; `rsp_id` follows the same sequence, shifted by 4 cycles.
- `rsp_ready`=0 with all requesters valid -> exactly 4 accepts, then `req_ready`=0. Raise `rsp_ready` -> responses arrive in issue order, and a new accept occurs in the first pop cycle.
- `credits`=0 with pop and pending request in the same cycle -> issue occurs and `credits` stays 0.
- Assert reset with 3 operations in flight -> no `rsp_valid` after release, `busy`=0, and the first new grant goes to requester 0 when all requesters are valid.

Source files
------------

// File: rtl/wallace_mul_arbiter.sv
// Round-robin front end sharing one LAT-cycle 4x4 multiplier among NREQ requesters.
// Owner tags ride a pipeline matched to the multiplier. Results drain in order through a credit-guarded FIFO.
module wallace_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 3,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [3:0]        mul_a,
  output logic [3:0]        mul_b,
  input  logic [7:0]        mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [7:0]        rsp_p,
  output logic              busy
);
  localparam int DEPTH = LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = $clog2(DEPTH);

  logic [IDW-1:0]           r_rr;
  logic [LAT-1:0]           r_tv;
  logic [LAT-1:0][IDW-1:0]  r_tid;
  logic [IDW+7:0]           r_mem [DEPTH];
  logic [PW-1:0]            r_wp, r_rp;
  logic [CW-1:0]            r_cnt, r_cred;

  logic           w_found, w_issue, w_pop, w_push;
  logic [IDW-1:0] w_gnt;

  // Cyclic priority search starting at r_rr.
  always_comb begin
    logic [IDW:0] idx;
    idx     = '0;
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, r_rr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!w_found && req_valid[idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = idx[IDW-1:0];
      end
    end
  end

  assign rsp_valid = (r_cnt != '0);
  assign w_pop     = rsp_valid & rsp_ready;
  assign w_push    = r_tv[LAT-1];
  // A pop in this cycle frees a slot in time to issue against it.
  assign w_issue   = resetn & w_found & ((r_cred != '0) | w_pop);
  assign req_ready = w_issue ? (NREQ'(1) << w_gnt) : '0;
  assign mul_a     = w_issue ? req_a[4*w_gnt +: 4] : 4'd0;
  assign mul_b     = w_issue ? req_b[4*w_gnt +: 4] : 4'd0;
  assign rsp_id    = r_mem[r_rp][IDW+7:8];
  assign rsp_p     = r_mem[r_rp][7:0];
  assign busy      = (r_cred != CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rr   <= '0;
      r_tv   <= '0;
      r_tid  <= '0;
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_cred <= CW'(DEPTH);
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_issue) r_rr <= (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
      // Stage 0 sits at the LSB; the cast drops the oldest stage.
      r_tv  <= LAT'({r_tv, w_issue});
      r_tid <= (LAT*IDW)'({r_tid, (w_issue ? w_gnt : IDW'(0))});
      if (w_push) begin
        r_mem[r_wp] <= {r_tid[LAT-1], mul_p};
        r_wp        <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
      end
      if (w_pop) r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
      r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
      r_cred <= r_cred - CW'(w_issue) + CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_wallace_mul_arbiter.sv
// Directed bench for wallace_mul_arbiter (NREQ=4, LAT=3) with a behavioural 3-stage multiplier.
module tb_wallace_mul_arbiter;
  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
  logic        busy;
  logic [7:0]  mp [3];
  logic [7:0]  prod [4];
  int nchk = 0;
  int nerr = 0;

  wallace_mul_arbiter #(.NREQ(4), .LAT(3)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_p(rsp_p),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    mp[0] <= {4'd0, mul_a} * {4'd0, mul_b};
    mp[1] <= mp[0];
    mp[2] <= mp[1];
  end
  assign mul_p = mp[2];

  always @(negedge clk)
    if (resetn === 1'b1 && int'(dut.r_cnt) > 4) begin
      nerr++;
      $display("FAIL fifo_count got %0d limit 4", dut.r_cnt);
    end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; req_valid = '0;
    repeat (3) cyc();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    req_a = 16'h1234; req_b = 16'h5678;
    repeat (4) cyc();
    #1;
    nchk++; if (req_ready !== 4'h0) begin nerr++; $display("FAIL rst_req_ready got %h exp 0", req_ready); end
    nchk++; if (mul_a !== 4'h0 || mul_b !== 4'h0) begin nerr++; $display("FAIL rst_mul got %h/%h exp 0/0", mul_a, mul_b); end
    nchk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL rst_flags got v=%b busy=%b exp 0/0", rsp_valid, busy); end
    nchk++; if (rsp_id !== 2'd0 || rsp_p !== 8'h00) begin nerr++; $display("FAIL rst_head got %0d/%h exp 0/00", rsp_id, rsp_p); end
    resetn = 1'b1; req_valid = '0;
    cyc();
  endtask

  task automatic test_single();
    req_valid = 4'b0100; req_a = 16'h0F00; req_b = 16'h0F00; rsp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 4'b0100) begin nerr++; $display("FAIL single_grant got %b exp 0100", req_ready); end
    nchk++; if (mul_a !== 4'hF || mul_b !== 4'hF) begin nerr++; $display("FAIL single_mul got %h/%h exp f/f", mul_a, mul_b); end
    for (int k = 1; k <= 5; k++) begin
      cyc();
      req_valid = '0;
      #1;
      nchk++; if (rsp_valid !== (k == 4)) begin nerr++; $display("FAIL single_valid t+%0d got %b", k, rsp_valid); end
      nchk++; if (busy !== (k <= 4)) begin nerr++; $display("FAIL single_busy t+%0d got %b", k, busy); end
      if (k == 4) begin
        nchk++; if (rsp_id !== 2'd2 || rsp_p !== 8'hE1) begin nerr++; $display("FAIL single_rsp got %0d/%h exp 2/e1", rsp_id, rsp_p); end
      end
    end
  endtask

  task automatic do_op(input int id, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    bit seen;
    seen = 1'b0;
    cyc();
    req_a = '0; req_b = '0;
    req_a[4*id +: 4] = a; req_b[4*id +: 4] = b;
    req_valid = 4'b1 << id;
    #1;
    nchk++; if (req_ready !== (4'b1 << id)) begin nerr++; $display("FAIL op_grant id=%0d got %b", id, req_ready); end
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc();
      req_valid = '0;
      #1;
      seen = rsp_valid;
    end
    nchk++;
    if (!seen) begin nerr++; $display("FAIL op_timeout id=%0d no response", id); end
    else if (rsp_id !== 2'(id) || rsp_p !== exp) begin
      nerr++; $display("FAIL op_rsp got %0d/%h exp %0d/%h", rsp_id, rsp_p, id, exp);
    end
    cyc();
  endtask

  task automatic test_operands();
    do_op(0, 4'hA, 4'h3, 8'h1E);
    do_op(1, 4'h0, 4'h9, 8'h00);
    do_op(3, 4'h7, 4'h8, 8'h38);
  endtask

  task automatic set_all();
    req_a = 16'hF531; req_b = 16'hE642;
    prod[0] = 8'h02; prod[1] = 8'h0C; prod[2] = 8'h1E; prod[3] = 8'hD2;
  endtask

  task automatic test_round_robin();
    do_reset();
    set_all();
    rsp_ready = 1'b1; req_valid = 4'hF;
    for (int c = 0; c < 12; c++) begin
      #1;
      nchk++; if (req_ready !== (4'b1 << (c % 4))) begin nerr++; $display("FAIL rr_grant c=%0d got %b", c, req_ready); end
      if (c >= 4) begin
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 4) % 4) || rsp_p !== prod[(c - 4) % 4]) begin
          nerr++; $display("FAIL rr_rsp c=%0d got v=%b %0d/%h exp %0d/%h", c, rsp_valid, rsp_id, rsp_p, (c - 4) % 4, prod[(c - 4) % 4]);
        end
      end else begin
        nchk++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rr_early c=%0d got v=%b exp 0", c, rsp_valid); end
      end
      cyc();
    end
    req_valid = '0;
    repeat (6) cyc();
  endtask

  task automatic test_stall();
    int got;
    int ids [4];
    ids[0] = 1; ids[1] = 2; ids[2] = 3; ids[3] = 0;
    do_reset();
    set_all();
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      #1;
      nchk++; if (req_ready !== ((c < 4) ? (4'b1 << c) : 4'b0)) begin nerr++; $display("FAIL stall_grant c=%0d got %b", c, req_ready); end
      if (c >= 7) begin
        nchk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_p !== 8'h02 || busy !== 1'b1) begin
          nerr++; $display("FAIL stall_hold c=%0d got v=%b %0d/%h busy=%b exp 1 0/02 1", c, rsp_valid, rsp_id, rsp_p, busy);
        end
      end
      cyc();
    end
    rsp_ready = 1'b1;
    #1;
    nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL bypass_grant got %b exp 0001", req_ready); end
    cyc();
    rsp_ready = 1'b0;
    #1;
    nchk++; if (req_ready !== 4'b0000) begin nerr++; $display("FAIL credit_zero got %b exp 0000", req_ready); end
    nchk++; if (rsp_id !== 2'd1 || rsp_p !== 8'h0C) begin nerr++; $display("FAIL after_pop got %0d/%h exp 1/0c", rsp_id, rsp_p); end
    cyc();
    req_valid = '0; rsp_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 4; k++) begin
      #1;
      if (rsp_valid === 1'b1) begin
        nchk++;
        if (rsp_id !== 2'(ids[got]) || rsp_p !== prod[ids[got]]) begin
          nerr++; $display("FAIL drain_order n=%0d got %0d/%h exp %0d/%h", got, rsp_id, rsp_p, ids[got], prod[ids[got]]);
        end
        got++;
      end
      cyc();
    end
    nchk++; if (got != 4) begin nerr++; $display("FAIL drain_count got %0d exp 4", got); end
    #1;
    nchk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL drain_idle got v=%b busy=%b exp 0/0", rsp_valid, busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_all();
    rsp_ready = 1'b1; req_valid = 4'hF;
    #1;
    nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL mid_first got %b exp 0001", req_ready); end
    repeat (3) cyc();
    resetn = 1'b0;
    #1;
    nchk++; if (req_ready !== 4'b0 || mul_a !== 4'h0) begin nerr++; $display("FAIL mid_force got %b/%h exp 0/0", req_ready, mul_a); end
    repeat (2) cyc();
    resetn = 1'b1; req_valid = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      nchk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin nerr++; $display("FAIL mid_flush k=%0d got v=%b busy=%b exp 0/0", k, rsp_valid, busy); end
      cyc();
    end
    req_valid = 4'hF;
    #1;
    nchk++; if (req_ready !== 4'b0001) begin nerr++; $display("FAIL mid_regrant got %b exp 0001", req_ready); end
    cyc();
    req_valid = '0;
    repeat (6) cyc();
  endtask

  initial begin
    resetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_operands();
    test_round_robin();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
